// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and FSM state type for the ALU issue stage.
// Optional feature macro used by the top: ALU_OPCODE_CHECK_EN.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_NOT = 4'b0101;
   localparam logic [3:0] OP_CMP = 4'b0110;
   localparam logic [3:0] OP_SHL = 4'b0111;
   localparam logic [3:0] OP_SHR = 4'b1000;
   localparam logic [3:0] OP_MAX = 4'b1000;

   localparam int unsigned FLAG_GT     = 4;
   localparam int unsigned FLAG_CARRY  = 2;
   localparam int unsigned FLAG_BORROW = 1;

   typedef enum logic {
      IDLE,
      EXEC
   } state_t;

   // Compare only updates flags; every other opcode writes its result back.
   function automatic logic op_writes_back(input logic [3:0] op);
      return op != OP_CMP;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: NREGS x WIDTH, two combinational read ports, one synchronous
// write port muxed between the external load path and the ALU writeback path.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREGS = 4,
   parameter int unsigned AW    = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load_en,
   input  logic [AW-1:0]    i_load_addr,
   input  logic [WIDTH-1:0] i_load_data,
   input  logic             i_wb_en,
   input  logic [AW-1:0]    i_wb_addr,
   input  logic [WIDTH-1:0] i_wb_data,
   input  logic [AW-1:0]    i_raddr1,
   input  logic [AW-1:0]    i_raddr2,
   output logic [WIDTH-1:0] o_rdata1,
   output logic [WIDTH-1:0] o_rdata2
);

   logic [WIDTH-1:0] r_mem [NREGS];
   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic [WIDTH-1:0] w_wdata;

   // Load and writeback are never enabled together (load is only honoured in IDLE).
   always_comb begin
      w_we    = i_load_en | i_wb_en;
      w_waddr = i_wb_en ? i_wb_addr : i_load_addr;
      w_wdata = i_wb_en ? i_wb_data : i_load_data;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   assign o_rdata1 = r_mem[i_raddr1];
   assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// Two-cycle issue/writeback stage in front of the combinational 8-bit ALU.
// Optional illegal-opcode rejection enabled by defining ALU_OPCODE_CHECK_EN.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREGS = 4,
   parameter int unsigned AW    = 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             LOAD_VALID,
   input  logic [AW-1:0]    LOAD_ADDR,
   input  logic [WIDTH-1:0] LOAD_DATA,
   input  logic             INSTR_VALID,
   output logic             INSTR_READY,
   input  logic [3:0]       INSTR_OPCODE,
   input  logic [AW-1:0]    INSTR_RD,
   input  logic [AW-1:0]    INSTR_RS1,
   input  logic [AW-1:0]    INSTR_RS2,
   output logic [WIDTH-1:0] DATA1,
   output logic [WIDTH-1:0] DATA2,
   output logic [3:0]       OPCODE,
   input  logic [WIDTH-1:0] DATAOUT,
   input  logic [4:0]       FLAGS,
   output logic             RESULT_VALID,
   output logic [WIDTH-1:0] RESULT_DATA,
   output logic [4:0]       RESULT_FLAGS,
   output logic             ERR
);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_data1, r_data2, r_result_data;
   logic [3:0]       r_opcode;
   logic [AW-1:0]    r_rd;
   logic [4:0]       r_result_flags;
   logic             r_result_valid;
   logic             w_ready, w_retire, w_load_en, w_accept, w_illegal, w_issue, w_wb_en;
   logic [WIDTH-1:0] w_rdata1, w_rdata2;

`ifdef ALU_OPCODE_CHECK_EN
   assign w_illegal = INSTR_OPCODE > OP_MAX;
`else
   assign w_illegal = 1'b0;
`endif

   assign w_accept = INSTR_VALID & w_ready;
   assign w_issue  = w_accept & ~w_illegal;
   assign w_wb_en  = w_retire & op_writes_back(r_opcode);

   always_ff @(posedge CLK) begin
      if (!RST_N) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_retire    = 1'b0;
      w_load_en   = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready   = ~LOAD_VALID;
            w_load_en = LOAD_VALID;
            if (w_issue) w_state_nxt = EXEC;
         end
         EXEC: begin
            w_retire    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_data1        <= '0;
         r_data2        <= '0;
         r_opcode       <= '0;
         r_rd           <= '0;
         r_result_data  <= '0;
         r_result_flags <= '0;
         r_result_valid <= 1'b0;
      end else begin
         r_result_valid <= w_retire;
         if (w_issue) begin
            r_data1  <= w_rdata1;
            r_data2  <= w_rdata2;
            r_opcode <= INSTR_OPCODE;
            r_rd     <= INSTR_RD;
         end
         if (w_retire) begin
            r_result_data  <= DATAOUT;
            r_result_flags <= FLAGS;
         end
      end
   end

`ifdef ALU_OPCODE_CHECK_EN
   logic r_err;
   always_ff @(posedge CLK) begin
      if (!RST_N) r_err <= 1'b0;
      else        r_err <= w_accept & w_illegal;
   end
   assign ERR = r_err;
`else
   assign ERR = 1'b0;
`endif

   alu_regfile #(
      .WIDTH(WIDTH),
      .NREGS(NREGS),
      .AW   (AW)
   ) u_regfile (
      .i_clk      (CLK),
      .i_rst_n    (RST_N),
      .i_load_en  (w_load_en),
      .i_load_addr(LOAD_ADDR),
      .i_load_data(LOAD_DATA),
      .i_wb_en    (w_wb_en),
      .i_wb_addr  (r_rd),
      .i_wb_data  (DATAOUT),
      .i_raddr1   (INSTR_RS1),
      .i_raddr2   (INSTR_RS2),
      .o_rdata1   (w_rdata1),
      .o_rdata2   (w_rdata2)
   );

   assign INSTR_READY  = w_ready;
   assign DATA1        = r_data1;
   assign DATA2        = r_data2;
   assign OPCODE       = r_opcode;
   assign RESULT_VALID = r_result_valid;
   assign RESULT_DATA  = r_result_data;
   assign RESULT_FLAGS = r_result_flags;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a tiny behavioural ALU closing the loop.
module tb_alu_issue_stage;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       LOAD_VALID;
   logic [1:0] LOAD_ADDR;
   logic [7:0] LOAD_DATA;
   logic       INSTR_VALID;
   logic       INSTR_READY;
   logic [3:0] INSTR_OPCODE;
   logic [1:0] INSTR_RD, INSTR_RS1, INSTR_RS2;
   logic [7:0] DATA1, DATA2, DATAOUT, RESULT_DATA;
   logic [3:0] OPCODE;
   logic [4:0] FLAGS, RESULT_FLAGS;
   logic       RESULT_VALID, ERR;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 CLK = ~CLK;

   alu_issue_stage #(.WIDTH(8), .NREGS(4), .AW(2)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .LOAD_VALID(LOAD_VALID), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
      .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .INSTR_OPCODE(INSTR_OPCODE),
      .INSTR_RD(INSTR_RD), .INSTR_RS1(INSTR_RS1), .INSTR_RS2(INSTR_RS2),
      .DATA1(DATA1), .DATA2(DATA2), .OPCODE(OPCODE),
      .DATAOUT(DATAOUT), .FLAGS(FLAGS),
      .RESULT_VALID(RESULT_VALID), .RESULT_DATA(RESULT_DATA),
      .RESULT_FLAGS(RESULT_FLAGS), .ERR(ERR)
   );

   // Minimal ALU: ADD (carry), AND, XOR, CMP (GT); anything else returns a marker value.
   always_comb begin
      logic [8:0] sum;
      sum     = {1'b0, DATA1} + {1'b0, DATA2};
      DATAOUT = 8'hA5;
      FLAGS   = '0;
      case (OPCODE)
         4'b0000: begin DATAOUT = sum[7:0]; FLAGS[2] = sum[8]; end
         4'b0010: DATAOUT = DATA1 & DATA2;
         4'b0100: DATAOUT = DATA1 ^ DATA2;
         4'b0110: begin DATAOUT = DATA1 - DATA2; FLAGS[4] = DATA1 > DATA2; end
         default: ;
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      LOAD_VALID = 1'b1; LOAD_ADDR = a; LOAD_DATA = d;
      tick();
      LOAD_VALID = 1'b0;
   endtask

   task automatic offer(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2);
      INSTR_VALID = 1'b1; INSTR_OPCODE = op; INSTR_RD = rd; INSTR_RS1 = rs1; INSTR_RS2 = rs2;
   endtask

   initial begin
      RST_N = 1'b0; LOAD_VALID = 1'b0; LOAD_ADDR = '0; LOAD_DATA = '0;
      INSTR_VALID = 1'b0; INSTR_OPCODE = '0; INSTR_RD = '0; INSTR_RS1 = '0; INSTR_RS2 = '0;
      tick(); tick();
      RST_N = 1'b1;
      check_eq("rst_ready", INSTR_READY, 1);
      check_eq("rst_valid", RESULT_VALID, 0);
      check_eq("rst_data1", DATA1, 0);
      check_eq("rst_rdata", RESULT_DATA, 0);
      check_eq("rst_err", ERR, 0);

      // ADD R0+R1 -> R2 with carry out
      load(0, 8'hF0); load(1, 8'h20);
      offer(4'b0000, 2, 0, 1);
      tick();
      INSTR_VALID = 1'b0;
      check_eq("add_data1", DATA1, 8'hF0);
      check_eq("add_data2", DATA2, 8'h20);
      check_eq("add_opcode", OPCODE, 0);
      check_eq("add_exec_ready", INSTR_READY, 0);
      check_eq("add_exec_valid", RESULT_VALID, 0);
      tick();
      check_eq("add_valid", RESULT_VALID, 1);
      check_eq("add_rdata", RESULT_DATA, 8'h10);
      check_eq("add_flags", RESULT_FLAGS, 5'b00100);
      check_eq("add_r2", dut.u_regfile.r_mem[2], 8'h10);
      tick();
      check_eq("add_valid_drop", RESULT_VALID, 0);
      check_eq("add_rdata_hold", RESULT_DATA, 8'h10);

      // CMP updates flags only
      load(0, 8'h05); load(1, 8'h03);
      offer(4'b0110, 3, 0, 1);
      tick();
      INSTR_VALID = 1'b0;
      tick();
      check_eq("cmp_valid", RESULT_VALID, 1);
      check_eq("cmp_flags", RESULT_FLAGS, 5'b10000);
      check_eq("cmp_r3", dut.u_regfile.r_mem[3], 0);
      tick();
      check_eq("cmp_pulse", RESULT_VALID, 0);

      // Load and instruction in the same IDLE cycle: load wins
      offer(4'b0100, 2, 0, 1);
      LOAD_VALID = 1'b1; LOAD_ADDR = 0; LOAD_DATA = 8'h3C;
      #1;
      check_eq("coll_ready", INSTR_READY, 0);
      tick();
      check_eq("coll_not_issued", DATA1, 8'h05);
      check_eq("coll_r0", dut.u_regfile.r_mem[0], 8'h3C);
      LOAD_VALID = 1'b0;
      #1;
      check_eq("coll_ready_back", INSTR_READY, 1);
      tick();
      check_eq("xor_data1", DATA1, 8'h3C);
      check_eq("xor_data2", DATA2, 8'h03);
      // Back-to-back: AND R2,R1 -> R3 held valid across the XOR's EXEC cycle
      offer(4'b0010, 3, 2, 1);
      tick();
      check_eq("xor_valid", RESULT_VALID, 1);
      check_eq("xor_rdata", RESULT_DATA, 8'h3F);
      check_eq("xor_ready_on_retire", INSTR_READY, 1);
      tick();
      INSTR_VALID = 1'b0;
      check_eq("and_data1", DATA1, 8'h3F);
      check_eq("and_opcode", OPCODE, 4'b0010);
      check_eq("and_exec_valid", RESULT_VALID, 0);
      LOAD_VALID = 1'b1; LOAD_ADDR = 1; LOAD_DATA = 8'h77;
      tick();
      LOAD_VALID = 1'b0;
      check_eq("and_valid", RESULT_VALID, 1);
      check_eq("and_r3", dut.u_regfile.r_mem[3], 8'h03);
      check_eq("exec_load_dropped", dut.u_regfile.r_mem[1], 8'h03);
      tick();

      // Reset during EXEC aborts the instruction
      offer(4'b0000, 0, 2, 3);
      tick();
      INSTR_VALID = 1'b0;
      check_eq("abort_issued", DATA1, 8'h3F);
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      check_eq("abort_valid", RESULT_VALID, 0);
      check_eq("abort_ready", INSTR_READY, 1);
      check_eq("abort_data1", DATA1, 0);
      check_eq("abort_rdata", RESULT_DATA, 0);
      check_eq("abort_rflags", RESULT_FLAGS, 0);
      for (int i = 0; i < 4; i++) check_eq($sformatf("abort_r%0d", i), dut.u_regfile.r_mem[i], 0);
      tick();
      check_eq("abort_no_late_valid", RESULT_VALID, 0);

      // Opcode above OP_MAX
      load(0, 8'h11); load(1, 8'h22);
      offer(4'b1010, 2, 0, 1);
      tick();
      INSTR_VALID = 1'b0;
`ifdef ALU_OPCODE_CHECK_EN
      check_eq("ill_err", ERR, 1);
      check_eq("ill_opcode", OPCODE, 0);
      check_eq("ill_data1", DATA1, 0);
      check_eq("ill_ready", INSTR_READY, 1);
      tick();
      check_eq("ill_err_pulse", ERR, 0);
      check_eq("ill_valid", RESULT_VALID, 0);
      check_eq("ill_r2", dut.u_regfile.r_mem[2], 0);
`else
      check_eq("ill_err", ERR, 0);
      check_eq("ill_opcode", OPCODE, 4'b1010);
      check_eq("ill_data1", DATA1, 8'h11);
      tick();
      check_eq("ill_valid", RESULT_VALID, 1);
      check_eq("ill_rdata", RESULT_DATA, 8'hA5);
      check_eq("ill_r2", dut.u_regfile.r_mem[2], 8'hA5);
      check_eq("ill_err_late", ERR, 0);
`endif
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
